// File: rtl/bram11_pkg.sv
// bram11_pkg: shared constants and response record for the bram11 controller slice.
package bram11_pkg;
    localparam int BRAM_DEPTH     = 11;
    localparam int BRAM_ADDR_W    = 12;
    localparam int BRAM_DATA_W    = 32;
    localparam int RSP_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [BRAM_DATA_W-1:0] data;
        logic                   err;
    } rsp_t;
endpackage

// File: rtl/bram11_rsp_fifo.sv
// bram11_rsp_fifo: 2-entry synchronous response FIFO, async active-high reset.
module bram11_rsp_fifo
    import bram11_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic push,
    input  logic pop,
    input  rsp_t din,
    output rsp_t dout,
    output logic full,
    output logic empty
);
    rsp_t       mem [RSP_FIFO_DEPTH];
    logic       wp, rp;
    logic [1:0] cnt;
    logic       do_push, do_pop;

    assign full    = cnt == 2'd2;
    assign empty   = cnt == 2'd0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (do_push) mem[wp] <= din;
            wp  <= wp ^ do_push;
            rp  <= rp ^ do_pop;
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
endmodule

// File: rtl/bram11_ctrl.sv
// bram11_ctrl: valid/ready initiator for the 11-word bram11, absorbing its 1-cycle read latency.
// Optional macro BRAM11_CTRL_STATS_EN adds saturating stat_rd/stat_wr/stat_err counters.
module bram11_ctrl
    import bram11_pkg::*;
#(
    parameter int ADDR_WIDTH = BRAM_ADDR_W,
    parameter int DATA_WIDTH = BRAM_DATA_W,
    parameter int DEPTH      = BRAM_DEPTH
)(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_wstrb,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
`ifdef BRAM11_CTRL_STATS_EN
    output logic [15:0]           stat_rd,
    output logic [15:0]           stat_wr,
    output logic [15:0]           stat_err,
`endif
    output logic                  EN,
    output logic [3:0]            WE,
    output logic [ADDR_WIDTH-1:0] A,
    output logic [DATA_WIDTH-1:0] Di,
    input  logic [DATA_WIDTH-1:0] Do
);
    logic                  accept, legal, pop, full, empty;
    logic                  inf_v, inf_rd, inf_err;
    logic [1:0]            credit;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] di_q;
    rsp_t                  push_d, dout;

    assign legal  = req_addr[1:0] == 2'b00 && req_addr < ADDR_WIDTH'(DEPTH * 4);
    assign accept = req_valid & req_ready;
    assign pop    = rsp_valid & rsp_ready;
    assign credit = (full ? 2'd2 : {1'b0, ~empty}) + {1'b0, inf_v};
    // A pop in this cycle frees its slot before the edge, allowing one request per cycle.
    assign req_ready = ~RST & ((credit - {1'b0, pop}) < 2'd2);

    assign EN = accept & legal;
    assign WE = EN ? req_wstrb : 4'b0000;
    assign A  = EN ? req_addr : a_q;
    assign Di = EN ? req_wdata : di_q;

    assign push_d.data = inf_rd ? Do : '0;
    assign push_d.err  = inf_err;

    assign rsp_valid = ~empty;
    assign rsp_data  = rsp_valid ? dout.data : '0;
    assign rsp_err   = rsp_valid & dout.err;

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            inf_v   <= 1'b0;
            inf_rd  <= 1'b0;
            inf_err <= 1'b0;
            a_q     <= '0;
            di_q    <= '0;
        end else begin
            inf_v   <= accept;
            inf_rd  <= EN & ~|req_wstrb;
            inf_err <= accept & ~legal;
            if (EN) begin
                a_q  <= req_addr;
                di_q <= req_wdata;
            end
        end

    bram11_rsp_fifo u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (inf_v),
        .pop   (pop),
        .din   (push_d),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    assert property (@(posedge CLK) disable iff (RST) !(inf_v && full));

`ifdef BRAM11_CTRL_STATS_EN
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            stat_rd  <= '0;
            stat_wr  <= '0;
            stat_err <= '0;
        end else begin
            if (EN & ~|req_wstrb & ~&stat_rd) stat_rd <= stat_rd + 16'd1;
            if (EN & |req_wstrb & ~&stat_wr) stat_wr <= stat_wr + 16'd1;
            if (accept & ~legal & ~&stat_err) stat_err <= stat_err + 16'd1;
        end
`endif
endmodule

// File: doc/bram11_ctrl.md
Name: bram11_ctrl

Overview:
- Initiator-side controller for the 11-word tap/data BRAM (bram11) in the FIR core.
- Accepts a valid/ready request stream of word reads and byte-masked writes, and drives the BRAM port (EN, WE[3:0], A, Di).
- Absorbs the BRAM's one-cycle read latency and returns in-order responses on a valid/ready stream with full backpressure.
- Sits between the FIR engine / AXI-Lite config path and the BRAM macro.

Parameters:
- ADDR_WIDTH, 12, byte-address width of the BRAM port and the request address.
- DATA_WIDTH, 32, data word width.
- DEPTH, 11, number of valid words; byte address must be < DEPTH*4.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_wstrb  in  4  byte write strobes; 4'b0000 means read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  address misaligned or out of range.
- EN  out  1  BRAM enable.
- WE  out  4  BRAM byte write enables.
- A  out  ADDR_WIDTH  BRAM byte address.
- Di  out  DATA_WIDTH  BRAM write data.
- Do  in  DATA_WIDTH  BRAM read data, valid the cycle after the sampling edge.

Behaviour:
- Reset values: req_ready=0 while RST is high, 1 on the first cycle after release; rsp_valid=0, rsp_data=0, rsp_err=0, EN=0, WE=0, A=0, Di=0. Internal credit counter and FIFO are cleared.
- Accept: a request is accepted when req_valid & req_ready are both high at a rising edge.
- BRAM drive: EN/WE/A/Di are combinational from the request during the accepting cycle.
  - Legal request: EN=1, WE=req_wstrb, A=req_addr, Di=req_wdata.
  - Otherwise EN=0 and WE=0; A and Di hold their last values.
- Legal request: req_addr[1:0]==0 and req_addr < DEPTH*4. An illegal request never touches the BRAM.
- Pipeline:
  - Access edge N: the BRAM samples the request.
  - Edge N+1: the response is pushed into a 2-entry response FIFO. Reads push Do; writes push data 0, err 0; illegal requests push data 0, err 1.
  - rsp_valid is high from the cycle after edge N+1, so minimum read latency from acceptance is 2 edges.
- Flow control:
  - credit = FIFO occupancy + in-flight count (0..1); req_ready = (credit < 2).
  - A simultaneous FIFO pop (rsp_valid & rsp_ready) in the same cycle frees a credit combinationally, so sustained throughput is 1 request per cycle when rsp_ready=1.
- Ordering: responses leave strictly in acceptance order, and the FIFO never overflows by construction. An assertion checks that a push to a full FIFO never occurs.
- Backpressure: with rsp_ready=0, rsp_data/rsp_err/rsp_valid hold stable until popped.
- Write then read, same address, back-to-back: the read returns the new data. The BRAM commits the write at edge N and the read samples at N+1.
- Partial write: only the bytes with WE set are updated; other bytes keep their prior contents.
- Reset mid-operation: in-flight and queued responses are discarded. BRAM contents are not cleared.
- No state machine beyond the credit counter, the in-flight flag (with op type/err bits) and the FIFO pointers.

Optional Feature:
- Macro BRAM11_CTRL_STATS_EN.
- Defined: adds outputs stat_rd, stat_wr, stat_err (16 bits each). Each increments on acceptance of a legal read, a legal write, or an illegal request respectively, saturates at 16'hFFFF, and is cleared by RST.
- Undefined: these ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package bram11_pkg holds:
  - constants BRAM_DEPTH=11, BRAM_ADDR_W=12, BRAM_DATA_W=32, RSP_FIFO_DEPTH=2;
  - response struct rsp_t {data, err}.
- One sub-module, bram11_rsp_fifo: a 2-entry synchronous FIFO with push/pop/full/empty and an async active-high reset.
- The controller instantiates this FIFO plus the access/credit logic.

Test Plan:
- Write words 0..10 (addr i*4, wstrb 4'hF, data i), then read each with rsp_ready=1 → 11 write acks (data 0, err 0), then rsp_data = 0,1,…,10 in order, each valid 2 edges after acceptance.
- Back-to-back reads at addr 0,4,8 with rsp_ready held 0 for 5 cycles → req_ready drops after 2 acceptances. Third request accepted after the first pop; responses 0,1,2 stable while stalled.
- Write 32'hAABBCCDD to addr 12, then wstrb 4'b0010 with data 32'h00001100, then read addr 12 → 32'hAABB11DD.
- Illegal addresses 44 and 6 → EN stays 0, two responses with err=1 and data 0; with BRAM11_CTRL_STATS_EN, stat_err=2.
- Write addr 20 data 5 and read addr 20 on consecutive accepting cycles → read returns 5.
- Assert RST while 2 responses are queued → rsp_valid=0 next cycle. After release, a read of addr 0 returns the previously written value 0.
